// File: rtl/wb_deserializer.sv
// wb_deserializer: receive side of the Wishbone serial link.
// Samples data_i on every ena_i=1 cycle and rebuilds 27-bit frames (three
// 9-bit symbols, MSB first). Each complete frame is placed in a holding
// register that a Wishbone master reads. Status flags and an interrupt
// line report the frame state.
//
// Ports:
//   CLK_I, RST_NI        clock, synchronous active-low reset
//   data_i, ena_i        serial bit and its qualifier
//   irq_o                mirrors the status valid flag
//   CYC_I, STB_I, WE_I   Wishbone cycle / strobe / write enable
//   ADR_I, DAT_I         Wishbone address / write data
//   ACK_O, ERR_O, DAT_O  Wishbone acknowledge / error / read data (registered)
//
// Register map:
//   ADR_DATA   read : {5'b0, hold[26:0]}, clears valid; write acked, ignored
//   ADR_STATUS read : {29'b0, frame_err, overrun, valid}; write: W1C [2:0]
//   other addresses : ERR_O, DAT_O=0, no side effects
module wb_deserializer #(
  parameter int unsigned GAP_MAX    = 16,
  parameter logic [31:0] ADR_DATA   = 32'h0000_0000,
  parameter logic [31:0] ADR_STATUS = 32'h0000_0004
) (
  input  logic        CLK_I,
  input  logic        RST_NI,
  input  logic        data_i,
  input  logic        ena_i,
  output logic        irq_o,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic [31:0] DAT_O
);

  localparam int unsigned FRAME_W = 27;
  localparam int unsigned BUS_W   = 32;
  localparam int unsigned BCNT_W  = 5;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);

  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(FRAME_W - 1);
  localparam logic [GAP_W-1:0]  GAP_LIM  = GAP_W'(GAP_MAX);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Receive path state
  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [BCNT_W-1:0]    bcnt_q,  bcnt_d;
  logic [GAP_W-1:0]     gap_q,   gap_d;
  logic [FRAME_W-1:0]   hold_q,  hold_d;

  // Status flags
  logic                 valid_q, valid_d;
  logic                 ovr_q,   ovr_d;
  logic                 ferr_q,  ferr_d;

  // Wishbone response registers
  logic                 ack_q,   ack_d;
  logic                 err_q,   err_d;
  logic [BUS_W-1:0]     dat_q,   dat_d;

  // Combinational events
  logic                 frame_done;
  logic                 gap_err;
  logic [GAP_W-1:0]     gap_inc;
  logic [FRAME_W-1:0]   frame_word;

  logic                 wb_req;
  logic                 hit_data;
  logic                 hit_stat;
  logic                 can_respond;
  logic                 rd_data;
  logic                 w1c;
  logic                 clr_valid;
  logic                 clr_ovr;
  logic                 clr_ferr;

  // Only the three flag bits of a write are meaningful
  logic                 unused_dat;
  assign unused_dat = ^DAT_I[BUS_W-1:3];

  assign gap_inc    = gap_q + GAP_W'(1);
  assign frame_word = {shift_q[FRAME_W-2:0], data_i};

  // Receive FSM: next state, shift register and counters
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcnt_d     = bcnt_q;
    gap_d      = gap_q;
    frame_done = 1'b0;
    gap_err    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ena_i) begin
          shift_d = {{(FRAME_W-1){1'b0}}, data_i};
          bcnt_d  = BCNT_W'(1);
          gap_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (ena_i) begin
          shift_d = frame_word;
          gap_d   = '0;
          if (bcnt_q == LAST_BIT) begin
            // 27th bit: frame complete
            frame_done = 1'b1;
            bcnt_d     = '0;
            state_d    = ST_IDLE;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end else begin
          gap_d = gap_inc;
          if (gap_inc == GAP_LIM) begin
            // Idle too long inside a frame: drop the partial frame
            gap_err = 1'b1;
            gap_d   = '0;
            bcnt_d  = '0;
            shift_d = '0;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Wishbone decode: one response per request, never on consecutive cycles
  always_comb begin
    wb_req      = CYC_I & STB_I;
    hit_data    = (ADR_I == ADR_DATA);
    hit_stat    = (ADR_I == ADR_STATUS);
    can_respond = wb_req & ~ack_q & ~err_q;

    ack_d = can_respond & (hit_data | hit_stat);
    err_d = can_respond & ~(hit_data | hit_stat);

    rd_data   = ack_d & hit_data & ~WE_I;
    w1c       = ack_d & hit_stat & WE_I;
    clr_valid = rd_data | (w1c & DAT_I[0]);
    clr_ovr   = w1c & DAT_I[1];
    clr_ferr  = w1c & DAT_I[2];

    dat_d = '0;
    if (ack_d && !WE_I) begin
      if (hit_data) begin
        dat_d = {{(BUS_W-FRAME_W){1'b0}}, hold_q};
      end else begin
        dat_d = {29'b0, ferr_q, ovr_q, valid_q};
      end
    end
  end

  // Holding register and status flags; set events beat clears
  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q & ~clr_valid;
    ovr_d   = ovr_q & ~clr_ovr;
    ferr_d  = ferr_q & ~clr_ferr;

    if (frame_done) begin
      hold_d  = frame_word;
      valid_d = 1'b1;
      // Overrun only if the previous frame is still unread after this edge
      if (valid_q && !clr_valid) begin
        ovr_d = 1'b1;
      end
    end

    if (gap_err) begin
      ferr_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bcnt_q  <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  assign irq_o = valid_q;
  assign ACK_O = ack_q;
  assign ERR_O = err_q;
  assign DAT_O = dat_q;

endmodule

// File: tb/tb_wb_deserializer.sv
// Directed testbench for wb_deserializer.
module tb_wb_deserializer;

  localparam int unsigned GAP_MAX = 16;

  localparam logic [31:0] A_DATA = 32'h0000_0000;
  localparam logic [31:0] A_STAT = 32'h0000_0004;
  localparam logic [31:0] A_BAD  = 32'h0000_0008;

  localparam logic [26:0] FRM_A = 27'h6F1_4A55;   // symbols 0x1BC, 0x0A5, 0x055
  localparam logic [26:0] FRM_1 = 27'h7FF_FFFF;
  localparam logic [26:0] FRM_B = 27'h123_4567;
  localparam logic [26:0] FRM_C = 27'h555_5555;

  logic        clk;
  logic        rst_n;
  logic        data;
  logic        ena;
  logic        irq;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        ack;
  logic        err;
  logic [31:0] rdat;

  int n_checks = 0;
  int n_pass   = 0;

  wb_deserializer #(
    .GAP_MAX    (GAP_MAX),
    .ADR_DATA   (A_DATA),
    .ADR_STATUS (A_STAT)
  ) dut (
    .CLK_I  (clk),
    .RST_NI (rst_n),
    .data_i (data),
    .ena_i  (ena),
    .irq_o  (irq),
    .CYC_I  (cyc),
    .STB_I  (stb),
    .WE_I   (we),
    .ADR_I  (adr),
    .DAT_I  (wdat),
    .ACK_O  (ack),
    .ERR_O  (err),
    .DAT_O  (rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ena = 1'b0;
    repeat (n) tick();
  endtask

  // Send bits hi..lo of a frame; optional 1-cycle gaps and one long gap after bit gap_at
  task automatic send_bits(input logic [26:0] w, input int hi, input int lo,
                           input bit toggle, input int gap_at, input int gap_len);
    for (int i = hi; i >= lo; i--) begin
      data = w[i];
      ena  = 1'b1;
      tick();
      ena  = 1'b0;
      if (i == gap_at) repeat (gap_len) tick();
      else if (toggle) tick();
    end
    ena = 1'b0;
  endtask

  task automatic send_frame(input logic [26:0] w);
    send_bits(w, 26, 0, 1'b0, -1, 0);
  endtask

  // Single Wishbone transfer; response sampled one cycle after the request
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic o_ack, output logic o_err, output logic [31:0] o_dat);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    tick();
    o_ack = ack; o_err = err; o_dat = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
    tick();
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic a_k, e_k;
    logic [31:0] d_k;
    wb_xfer(1'b0, a, 32'h0, a_k, e_k, d_k);
    check({tag, "_ack"}, 32'(a_k), 32'h1);
    check(tag, d_k, exp);
  endtask

  logic        r_ack, r_err;
  logic [31:0] r_dat;

  initial begin
    rst_n = 1'b0; data = 1'b0; ena = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
    #1;
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_ack",  32'(ack),  32'h0);
    check("rst_err",  32'(err),  32'h0);
    check("rst_dat",  rdat,      32'h0);
    check("rst_irq",  32'(irq),  32'h0);
    idle(3);
    rd_check("rst_stat", A_STAT, 32'h0);
    rd_check("rst_hold", A_DATA, 32'h0);
    check("rst_dat_after_ack", rdat, 32'h0);

    // Continuous frame
    send_bits(FRM_A, 26, 1, 1'b0, -1, 0);
    check("irq_before_bit27", 32'(irq), 32'h0);
    send_bits(FRM_A, 0, 0, 1'b0, -1, 0);
    check("irq_after_bit27", 32'(irq), 32'h1);
    rd_check("frm_stat", A_STAT, 32'h1);
    rd_check("frm_data", A_DATA, 32'h06F1_4A55);
    rd_check("frm_stat_clr", A_STAT, 32'h0);
    check("frm_irq_clr", 32'(irq), 32'h0);

    // Toggling enable plus one GAP_MAX-1 idle stretch
    send_bits(FRM_A, 26, 0, 1'b1, 13, GAP_MAX - 1);
    rd_check("gap_ok_stat", A_STAT, 32'h1);
    rd_check("gap_ok_data", A_DATA, 32'h06F1_4A55);

    // Partial frame abandoned after GAP_MAX idle cycles
    send_bits(FRM_1, 26, 17, 1'b0, -1, 0);
    idle(GAP_MAX);
    rd_check("ferr_stat", A_STAT, 32'h4);
    check("ferr_irq", 32'(irq), 32'h0);
    rd_check("ferr_hold", A_DATA, 32'h06F1_4A55);
    wb_xfer(1'b1, A_STAT, 32'h4, r_ack, r_err, r_dat);
    check("w1c_ack", 32'(r_ack), 32'h1);
    check("w1c_dat", r_dat, 32'h0);
    rd_check("w1c_stat", A_STAT, 32'h0);
    send_frame(FRM_B);
    rd_check("after_ferr_data", A_DATA, 32'h0123_4567);

    // Overrun: two frames with no read between
    send_frame(FRM_A);
    send_frame(FRM_1);
    rd_check("ovr_stat", A_STAT, 32'h3);
    rd_check("ovr_data", A_DATA, 32'h07FF_FFFF);
    rd_check("ovr_stat2", A_STAT, 32'h2);
    wb_xfer(1'b1, A_STAT, 32'h2, r_ack, r_err, r_dat);
    rd_check("ovr_w1c_stat", A_STAT, 32'h0);

    // Frame completing on the same edge as a data-read ack
    send_frame(FRM_A);
    send_bits(FRM_C, 26, 1, 1'b0, -1, 0);
    data = FRM_C[0]; ena = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_DATA;
    tick();
    check("coll_ack", 32'(ack), 32'h1);
    check("coll_dat", rdat, 32'h06F1_4A55);
    check("coll_irq", 32'(irq), 32'h1);
    ena = 1'b0; cyc = 1'b0; stb = 1'b0;
    tick();
    rd_check("coll_stat", A_STAT, 32'h1);
    rd_check("coll_data", A_DATA, 32'h0555_5555);

    // Unmapped address: error, no side effects
    send_frame(FRM_B);
    wb_xfer(1'b0, A_BAD, 32'h0, r_ack, r_err, r_dat);
    check("bad_rd_err", 32'(r_err), 32'h1);
    check("bad_rd_ack", 32'(r_ack), 32'h0);
    check("bad_rd_dat", r_dat, 32'h0);
    check("bad_err_one_cycle", 32'(err), 32'h0);
    wb_xfer(1'b1, A_BAD, 32'h7, r_ack, r_err, r_dat);
    check("bad_wr_err", 32'(r_err), 32'h1);
    check("bad_wr_ack", 32'(r_ack), 32'h0);
    rd_check("bad_stat", A_STAT, 32'h1);

    // Request held high: ack every other cycle
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STAT;
    tick(); check("hold_ack0", 32'(ack), 32'h1);
    tick(); check("hold_ack1", 32'(ack), 32'h0);
    check("hold_dat1", rdat, 32'h0);
    tick(); check("hold_ack2", 32'(ack), 32'h1);
    tick(); check("hold_ack3", 32'(ack), 32'h0);
    cyc = 1'b0; stb = 1'b0;
    tick();
    rd_check("hold_data", A_DATA, 32'h0123_4567);

    // Reset during bit 15 of a frame while a frame is pending
    send_frame(FRM_1);
    send_bits(FRM_A, 26, 13, 1'b0, -1, 0);
    data = FRM_A[12]; ena = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; ena = 1'b0;
    check("mid_rst_irq", 32'(irq), 32'h0);
    check("mid_rst_ack", 32'(ack), 32'h0);
    rd_check("mid_rst_stat", A_STAT, 32'h0);
    rd_check("mid_rst_hold", A_DATA, 32'h0);
    send_frame(FRM_A);
    rd_check("mid_rst_stat2", A_STAT, 32'h1);
    rd_check("mid_rst_data", A_DATA, 32'h06F1_4A55);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
